bin_bcd_seq: RTL and testbench



---
 rtl/bin_bcd_seq.sv | 190 +++++++++++++++++++
 tb/tb_bin_bcd_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_bcd_seq
// Iterative binary-to-BCD converter (double-dabble) with valid/ready flow
// control on both sides, optional two's-complement input and a capacity
// overflow flag.
//
// Parameters
//   BIN_W   input binary width (2..32)
//   DIGITS  number of BCD output digits (1..10)
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   input word present
//   in_ready   converter can accept a word (IDLE)
//   in_data    binary input word
//   in_signed  treat in_data as two's complement (sampled with in_data)
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   out_bcd    BCD result, digit 0 (units) in bits [3:0]
//   out_neg    result is negative
//   out_ovf    magnitude >= 10^DIGITS; out_bcd holds magnitude mod 10^DIGITS
//   busy       conversion in progress (CONV)
// -----------------------------------------------------------------------------
module bin_bcd_seq #(
  parameter int BIN_W  = 13,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_data,
  input  logic                  in_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  // The counter reaches BIN_W after the last shift; the cycle spent at that
  // value transfers the result into the output registers.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Add 3 to every digit that is 5 or more; digits never carry into each other.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

  // Magnitude in BIN_W unsigned bits; the most negative value maps onto
  // 2^(BIN_W-1), which still fits.
  function automatic logic [BIN_W-1:0] magnitude(input logic [BIN_W-1:0] data,
                                                 input logic             is_signed);
    if (is_signed && data[BIN_W-1]) begin
      return ~data + {{(BIN_W-1){1'b0}}, 1'b1};
    end else begin
      return data;
    end
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BIN_W-1:0]   r_mag;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf_sticky;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic [BCD_W-1:0]   r_out_bcd;
  logic               r_out_neg;
  logic               r_out_ovf;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_bcd_shift;
  logic               w_carry;
  logic               w_last;

  assign w_last = (r_cnt == LAST_CNT);

  // One double-dabble step: adjust digits, then shift {bcd, mag} left by one.
  always_comb begin
    w_adj       = dabble_adjust(r_bcd);
    w_carry     = w_adj[BCD_W-1];
    w_bcd_shift = {w_adj[BCD_W-2:0], r_mag[BIN_W-1]};
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = CONV;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CONV: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = CONV;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register and datapath: accept, shift, and result capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_mag        <= {BIN_W{1'b0}};
      r_bcd        <= {BCD_W{1'b0}};
      r_ovf_sticky <= 1'b0;
      r_cnt        <= {CNT_W{1'b0}};
      r_neg        <= 1'b0;
      r_out_bcd    <= {BCD_W{1'b0}};
      r_out_neg    <= 1'b0;
      r_out_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mag        <= magnitude(in_data, in_signed);
            r_neg        <= in_signed & in_data[BIN_W-1];
            r_bcd        <= {BCD_W{1'b0}};
            r_ovf_sticky <= 1'b0;
            r_cnt        <= {CNT_W{1'b0}};
          end
        end
        CONV: begin
          if (w_last) begin
            // Outputs only change here, so they hold through DONE and after it.
            r_out_bcd <= r_bcd;
            r_out_ovf <= r_ovf_sticky;
            r_out_neg <= r_neg;
          end else begin
            r_bcd        <= w_bcd_shift;
            r_mag        <= {r_mag[BIN_W-2:0], 1'b0};
            r_ovf_sticky <= r_ovf_sticky | w_carry;
            r_cnt        <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == CONV);
  assign out_valid = (r_state == DONE);
  assign out_bcd   = r_out_bcd;
  assign out_neg   = r_out_neg;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_bcd_seq
// Scoreboard bench for bin_bcd_seq. Instance A uses the default 13-bit /
// 4-digit configuration, instance B a 14-bit / 4-digit one where overflow is
// reachable. Drivers push expected results; negedge monitors pop and compare
// on each output handshake and measure accept-to-valid latency.
// -----------------------------------------------------------------------------
module tb_bin_bcd_seq;

  typedef struct {
    longint bcd;
    bit     neg;
    bit     ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance A (13 bits, 4 digits) ----------------
  logic        a_rst_n     = 1'b0;
  logic        a_in_valid  = 1'b0;
  logic        a_in_ready;
  logic [12:0] a_in_data   = 13'd0;
  logic        a_in_signed = 1'b0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b1;
  logic [15:0] a_out_bcd;
  logic        a_out_neg;
  logic        a_out_ovf;
  logic        a_busy;
  bit          a_stall_en  = 1'b0;
  bit          a_ready_force = 1'b1;
  bit          a_prev_valid  = 1'b0;
  exp_t        a_q[$];
  int          a_lat_q[$];

  bin_bcd_seq #(.BIN_W(13), .DIGITS(4)) u_dut_a (
    .clk(clk), .reset_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_signed(a_in_signed), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_bcd(a_out_bcd), .out_neg(a_out_neg),
    .out_ovf(a_out_ovf), .busy(a_busy)
  );

  // ---------------- instance B (14 bits, 4 digits) ----------------
  logic        b_rst_n     = 1'b0;
  logic        b_in_valid  = 1'b0;
  logic        b_in_ready;
  logic [13:0] b_in_data   = 14'd0;
  logic        b_in_signed = 1'b0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [15:0] b_out_bcd;
  logic        b_out_neg;
  logic        b_out_ovf;
  logic        b_busy;
  bit          b_stall_en  = 1'b0;
  bit          b_prev_valid = 1'b0;
  exp_t        b_q[$];
  int          b_lat_q[$];

  bin_bcd_seq #(.BIN_W(14), .DIGITS(4)) u_dut_b (
    .clk(clk), .reset_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_signed(b_in_signed), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_bcd(b_out_bcd), .out_neg(b_out_neg),
    .out_ovf(b_out_ovf), .busy(b_busy)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: plain decimal arithmetic on the signed/unsigned value.
  function automatic exp_t model(input longint raw, input bit sgn, input int bw, input int digs);
    exp_t   e;
    longint mag;
    longint pow10;
    longint rem;
    e.neg = 1'b0;
    mag   = raw;
    if (sgn && (((raw >> (bw - 1)) & 64'd1) == 64'd1)) begin
      e.neg = 1'b1;
      mag   = (64'd1 << bw) - raw;
    end
    pow10 = 1;
    for (int i = 0; i < digs; i++) pow10 = pow10 * 10;
    e.ovf = (mag >= pow10);
    rem   = mag % pow10;
    e.bcd = 0;
    for (int i = 0; i < digs; i++) begin
      e.bcd = e.bcd | ((rem % 10) << (4 * i));
      rem   = rem / 10;
    end
    return e;
  endfunction

  function automatic bit bcd_legal(input longint v, input int digs);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < digs; i++) begin
      if (((v >> (4 * i)) & 64'hF) > 64'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic exp_t mk(input longint bcd, input bit neg, input bit ovf);
    exp_t e;
    e.bcd = bcd;
    e.neg = neg;
    e.ovf = ovf;
    return e;
  endfunction

  // out_ready drivers: random stalls or a directed level.
  always @(posedge clk) begin
    #2;
    a_out_ready = a_stall_en ? ($urandom_range(0, 3) != 0) : a_ready_force;
    b_out_ready = b_stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor A: latency, result comparison at each output handshake.
  always @(negedge clk) begin
    if (!a_rst_n) begin
      a_lat_q.delete();
      a_prev_valid = 1'b0;
    end else begin
      if (a_in_valid && a_in_ready) a_lat_q.push_back(cyc + 1);
      if (a_out_valid && !a_prev_valid) begin
        if (a_lat_q.size() == 0) check("a_unexpected_valid", 1, 0);
        else check("a_latency", cyc - a_lat_q.pop_front(), 14);
      end
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) begin
          check("a_unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = a_q.pop_front();
          check("a_bcd", a_out_bcd, e.bcd);
          check("a_neg", a_out_neg, e.neg);
          check("a_ovf", a_out_ovf, e.ovf);
          check("a_legal", bcd_legal(a_out_bcd, 4), 1);
        end
      end
      a_prev_valid = a_out_valid;
    end
  end

  // Monitor B: same as A for the 14-bit instance.
  always @(negedge clk) begin
    if (!b_rst_n) begin
      b_lat_q.delete();
      b_prev_valid = 1'b0;
    end else begin
      if (b_in_valid && b_in_ready) b_lat_q.push_back(cyc + 1);
      if (b_out_valid && !b_prev_valid) begin
        if (b_lat_q.size() == 0) check("b_unexpected_valid", 1, 0);
        else check("b_latency", cyc - b_lat_q.pop_front(), 15);
      end
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) begin
          check("b_unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = b_q.pop_front();
          check("b_bcd", b_out_bcd, e.bcd);
          check("b_neg", b_out_neg, e.neg);
          check("b_ovf", b_out_ovf, e.ovf);
          check("b_legal", bcd_legal(b_out_bcd, 4), 1);
        end
      end
      b_prev_valid = b_out_valid;
    end
  end

  task automatic send_a(input logic [12:0] d, input logic s);
    int n;
    n = 0;
    @(posedge clk); #1;
    a_in_data = d; a_in_signed = s; a_in_valid = 1'b1;
    while (!a_in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) check("a_send_timeout", n, 0);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [13:0] d, input logic s);
    int n;
    n = 0;
    @(posedge clk); #1;
    b_in_data = d; b_in_signed = s; b_in_valid = 1'b1;
    while (!b_in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) check("b_send_timeout", n, 0);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain(input bit sel_b);
    int n;
    n = 0;
    while ((sel_b ? b_q.size() : a_q.size()) > 0 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) check(sel_b ? "b_drain_timeout" : "a_drain_timeout", n, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic longint rand_word(input int bw);
    int     sel;
    longint v;
    sel = $urandom_range(0, 7);
    case (sel)
      0:       v = 0;
      1:       v = (64'd1 << bw) - 1;
      2:       v = 64'd1 << (bw - 1);
      default: v = longint'($urandom) & ((64'd1 << bw) - 1);
    endcase
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Directed and random stimulus.
  initial begin
    longint v;
    bit     s;
    int     n;

    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("a_rst_in_ready", a_in_ready, 1);
    check("a_rst_out_valid", a_out_valid, 0);
    check("a_rst_busy", a_busy, 0);
    check("a_rst_out_bcd", a_out_bcd, 0);
    check("a_rst_out_neg", a_out_neg, 0);
    check("a_rst_out_ovf", a_out_ovf, 0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    // Default configuration directed words
    a_q.push_back(mk(64'h8191, 1'b0, 1'b0)); send_a(13'd8191, 1'b0);
    a_q.push_back(mk(64'h4096, 1'b1, 1'b0)); send_a(13'h1000, 1'b1);
    a_q.push_back(mk(64'h0001, 1'b1, 1'b0)); send_a(13'h1FFF, 1'b1);
    a_q.push_back(mk(64'h0000, 1'b0, 1'b0)); send_a(13'h0000, 1'b1);
    drain(1'b0);

    // Back-pressure: result held, second word refused while DONE.
    a_ready_force = 1'b0;
    a_q.push_back(mk(64'h1234, 1'b0, 1'b0)); send_a(13'd1234, 1'b0);
    n = 0;
    while (!a_out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("a_bp_valid_seen", a_out_valid, 1);
    a_in_data = 13'd4321; a_in_signed = 1'b0; a_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("a_bp_out_valid", a_out_valid, 1);
      check("a_bp_out_bcd", a_out_bcd, 64'h1234);
      check("a_bp_in_ready", a_in_ready, 0);
      check("a_bp_busy", a_busy, 0);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_ready_force = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("a_bp_release_in_ready", a_in_ready, 1);
    check("a_bp_release_out_valid", a_out_valid, 0);
    check("a_bp_hold_bcd", a_out_bcd, 64'h1234);
    drain(1'b0);

    // Reset in the middle of a conversion (counter at 5).
    send_a(13'd1000, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("a_midrst_busy", a_busy, 1);
    a_rst_n = 1'b0;
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    @(negedge clk);
    check("a_midrst_in_ready", a_in_ready, 1);
    check("a_midrst_out_valid", a_out_valid, 0);
    check("a_midrst_busy_low", a_busy, 0);
    check("a_midrst_out_bcd", a_out_bcd, 0);
    a_q.push_back(mk(64'h1234, 1'b0, 1'b0)); send_a(13'd1234, 1'b0);
    drain(1'b0);

    // 14-bit instance: overflow, then sticky bit cleared per word.
    b_q.push_back(mk(64'h6383, 1'b0, 1'b1)); send_b(14'd16383, 1'b0);
    b_q.push_back(mk(64'h9999, 1'b0, 1'b0)); send_b(14'd9999, 1'b0);
    b_q.push_back(mk(64'h8192, 1'b1, 1'b0)); send_b(14'h2000, 1'b1);
    drain(1'b1);

    // Random sweeps with random out_ready stalls.
    a_stall_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      v = rand_word(13);
      s = 1'($urandom_range(0, 1));
      a_q.push_back(model(v, s, 13, 4));
      send_a(13'(v), s);
    end
    drain(1'b0);
    a_stall_en = 1'b0;

    b_stall_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      v = rand_word(14);
      s = 1'($urandom_range(0, 1));
      b_q.push_back(model(v, s, 14, 4));
      send_b(14'(v), s);
    end
    drain(1'b1);
    b_stall_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
